// File: rtl/div.sv
// Multi-cycle 32-bit radix-2 restoring divider for the EX-stage DIV/DIVU path.
// Returns {remainder, quotient} with a registered ready flag after 32 iteration steps.
module div (
   input  logic        clk,
   input  logic        rst,
   input  logic        signed_div_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   input  logic        start_i,
   input  logic        annul_i,
   output logic [63:0] result_o,
   output logic        ready_o
);

   localparam int unsigned DataW  = 32;
   localparam int unsigned CntW   = 6;
   localparam int unsigned PartW  = 2 * DataW + 1;
   localparam int unsigned Steps  = 32;

   typedef enum logic [1:0] {
      DIV_FREE,
      DIV_BY_ZERO,
      DIV_ON,
      DIV_END
   } state_t;

   state_t              state, state_n;
   logic [PartW-1:0]    dividend, dividend_n;
   logic [DataW-1:0]    divisor, divisor_n;
   logic [CntW-1:0]     cnt, cnt_n;
   logic                neg1, neg1_n;
   logic                neg2, neg2_n;
   logic                is_signed, is_signed_n;
   logic [2*DataW-1:0]  result_n;
   logic                ready_n;

   logic [DataW:0]      diff;
   logic [DataW-1:0]    abs1, abs2;
   logic [DataW-1:0]    quot, rem;

   // Operand magnitudes; the most negative value maps to 2^31 as an unsigned magnitude
   assign abs1 = (signed_div_i && opdata1_i[DataW-1]) ? (~opdata1_i + DataW'(1)) : opdata1_i;
   assign abs2 = (signed_div_i && opdata2_i[DataW-1]) ? (~opdata2_i + DataW'(1)) : opdata2_i;

   assign diff = {1'b0, dividend[2*DataW-1:DataW]} - {1'b0, divisor};

   // Sign fix-up applied once the magnitude division has finished
   assign quot = (is_signed && (neg1 ^ neg2)) ? (~dividend[DataW-1:0] + DataW'(1))
                                              : dividend[DataW-1:0];
   assign rem  = (is_signed && neg1) ? (~dividend[PartW-1:DataW+1] + DataW'(1))
                                     : dividend[PartW-1:DataW+1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= DIV_FREE;
         dividend  <= '0;
         divisor   <= '0;
         cnt       <= '0;
         neg1      <= 1'b0;
         neg2      <= 1'b0;
         is_signed <= 1'b0;
         result_o  <= '0;
         ready_o   <= 1'b0;
      end else begin
         state     <= state_n;
         dividend  <= dividend_n;
         divisor   <= divisor_n;
         cnt       <= cnt_n;
         neg1      <= neg1_n;
         neg2      <= neg2_n;
         is_signed <= is_signed_n;
         result_o  <= result_n;
         ready_o   <= ready_n;
      end
   end

   always_comb begin
      state_n     = state;
      dividend_n  = dividend;
      divisor_n   = divisor;
      cnt_n       = cnt;
      neg1_n      = neg1;
      neg2_n      = neg2;
      is_signed_n = is_signed;
      result_n    = '0;
      ready_n     = 1'b0;

      unique case (state)
         DIV_FREE: begin
            if (start_i && !annul_i) begin
               if (opdata2_i == '0) begin
                  state_n = DIV_BY_ZERO;
               end else begin
                  state_n     = DIV_ON;
                  cnt_n       = '0;
                  dividend_n  = {DataW'(0), abs1, 1'b0};
                  divisor_n   = abs2;
                  neg1_n      = opdata1_i[DataW-1];
                  neg2_n      = opdata2_i[DataW-1];
                  is_signed_n = signed_div_i;
               end
            end
         end

         DIV_BY_ZERO: begin
            state_n    = DIV_END;
            dividend_n = '0;
            ready_n    = 1'b1;
         end

         DIV_ON: begin
            if (annul_i || !start_i) begin
               state_n    = DIV_FREE;
               dividend_n = '0;
            end else if (cnt != CntW'(Steps)) begin
               if (diff[DataW]) begin
                  dividend_n = dividend << 1;
               end else begin
                  dividend_n = {diff[DataW-1:0], dividend[DataW-1:0], 1'b1};
               end
               cnt_n = cnt + CntW'(1);
            end else begin
               state_n  = DIV_END;
               cnt_n    = '0;
               result_n = {rem, quot};
               ready_n  = 1'b1;
            end
         end

         DIV_END: begin
            if (start_i) begin
               result_n = result_o;
               ready_n  = 1'b1;
            end else begin
               state_n = DIV_FREE;
            end
         end

         default: state_n = DIV_FREE;
      endcase
   end

endmodule

// File: tb/tb_div.sv
// Directed, table-driven checks for the radix-2 divider, plus annul/reset/hold sequences.
module tb_div;

   logic        clk = 1'b0;
   logic        rst;
   logic        signed_div;
   logic [31:0] op1, op2;
   logic        start, annul;
   logic [63:0] result;
   logic        ready;

   int passed = 0;
   int total  = 0;

   div dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div),
      .opdata1_i    (op1),
      .opdata2_i    (op2),
      .start_i      (start),
      .annul_i      (annul),
      .result_o     (result),
      .ready_o      (ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
      int          lat;
   } vec_t;

   localparam int NV = 12;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Starts a division just after a falling edge, scrambles operands after acceptance,
   // and measures the number of cycles until ready rises.
   task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int lat);
      int  cycles;
      bit  got;
      signed_div = sgn; op1 = a; op2 = b; start = 1'b1;
      cycles = 0; got = 1'b0;
      while (!got && cycles < 100) begin
         @(negedge clk);
         cycles++;
         if (cycles == 1) begin
            op1 = ~a;
            op2 = b ^ 32'h5a5a_0001;
            signed_div = ~sgn;
         end
         if (ready) got = 1'b1;
      end
      check({name, " latency"}, 64'(cycles), 64'(lat));
      check({name, " result"}, result, exp);
      start = 1'b0;
      @(negedge clk);
      check({name, " ready drop"}, 64'(ready), 64'd0);
      check({name, " result clear"}, result, 64'd0);
   endtask

   initial begin
      int          seen;
      logic [63:0] held;

      vecs[0]  = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 34};
      vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'h00000002,   64'hFFFFFFFF_FFFFFFFD, 34};
      vecs[2]  = '{1'b1, 32'h00000007,   32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 34};
      vecs[3]  = '{1'b0, 32'h12345678,   32'h00000000,   64'h0,                 2};
      vecs[4]  = '{1'b1, 32'h12345678,   32'h00000000,   64'h0,                 2};
      vecs[5]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 34};
      vecs[6]  = '{1'b0, 32'hFFFFFFFF,   32'h00000001,   64'h00000000_FFFFFFFF, 34};
      vecs[7]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   64'h80000000_00000000, 34};
      vecs[8]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   64'hFFFFFFFE_0000000E, 34};
      vecs[9]  = '{1'b0, 32'hFFFFFFF9,   32'h00000002,   64'h00000001_7FFFFFFC, 34};
      vecs[10] = '{1'b0, 32'd5,          32'd10,         64'h00000005_00000000, 34};
      vecs[11] = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   64'hFFFFFFFF_00000003, 34};

      rst = 1'b1; signed_div = 1'b0; op1 = '0; op2 = '0; start = 1'b0; annul = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset ready", 64'(ready), 64'd0);
      check("reset result", result, 64'd0);

      for (int i = 0; i < NV; i++) begin
         run_div($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
         @(negedge clk);
      end

      // Annul partway through the iterations: nothing reported, then a clean rerun
      signed_div = 1'b0; op1 = 32'hFFFFFFFF; op2 = 32'd3; start = 1'b1;
      repeat (11) @(negedge clk);
      annul = 1'b1;
      @(negedge clk);
      annul = 1'b0; start = 1'b0;
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (ready) seen++;
      end
      check("annul no ready", 64'(seen), 64'd0);
      run_div("after annul", 1'b0, 32'hFFFFFFFF, 32'd3, 64'h00000000_55555555, 34);
      @(negedge clk);

      // Holding start in the end state keeps the outputs stable
      signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
      seen = 0;
      while (!ready && seen < 100) begin
         @(negedge clk);
         seen++;
      end
      check("hold latency", 64'(seen), 64'd34);
      held = 64'h00000002_0000000E;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("hold ready %0d", k), 64'(ready), 64'd1);
         check($sformatf("hold result %0d", k), result, held);
      end

      // Asynchronous reset while the result is being held clears outputs before any edge
      #2 rst = 1'b1;
      #1;
      check("async rst ready", 64'(ready), 64'd0);
      check("async rst result", result, 64'd0);
      @(negedge clk);
      start = 1'b0; rst = 1'b0;
      @(negedge clk);

      // Reset mid-iteration, then a fresh division completes normally
      signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd10; start = 1'b1;
      repeat (15) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("mid rst ready", 64'(ready), 64'd0);
      check("mid rst result", result, 64'd0);
      @(negedge clk);
      start = 1'b0; rst = 1'b0;
      @(negedge clk);
      run_div("after rst", 1'b0, 32'd1000, 32'd10, 64'h00000000_00000064, 34);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
